hilo_mul_unit: RTL and testbench
================================

# hilo_mul_unit

Iterative 32x32 multiply / multiply-accumulate unit with architectural HI/LO registers. It sits directly downstream of the decoder in the execute stage. It consumes the decoder's `ALUOp`, `MULOp` and `Func` outputs together with the two register operands. It asserts `Stall` so the pipeline interlocks on HI/LO hazards.

## Interface
Parameters:
- `WIDTH`, 32: operand width; HI and LO are each `WIDTH` bits.

Ports:
- `Clock`  in  1  system clock; all state updates on the rising edge.
- `Reset`  in  1  asynchronous, active-high reset.
- `ALUOp`  in  1  decoder ALU-class flag.
- `MULOp`  in  1  decoder SPECIAL2-class flag.
- `Func`  in  6  decoder function code.
- `Valid`  in  1  instruction in execute is live; qualifies all requests.
- `A`  in  WIDTH  rs operand.
- `B`  in  WIDTH  rt operand.
- `Busy`  out  1  iterative operation in progress.
- `Done`  out  1  one-cycle pulse; HI/LO or `MulOut` updated on this edge.
- `Stall`  out  1  pipeline must hold the current instruction.
- `HiLoOut`  out  WIDTH  MFHI/MFLO read data (combinational).
- `MulOut`  out  WIDTH  registered low word of the last MUL.
- `HI`, `LO`  out  WIDTH  architectural registers, exposed for debug.

## Operation
- Decoded ops with `Valid=1`:
  - `ALUOp=1`: MFHI 6'h10, MTHI 6'h11, MFLO 6'h12, MTLO 6'h13, MULT 6'h18, MULTU 6'h19.
  - `MULOp=1`: MADD 6'h00, MADDU 6'h01, MUL 6'h02, MSUB 6'h04, MSUBU 6'h05.
  - All other combinations are ignored.
- FSM states: IDLE, RUN, FIN.
  - IDLE -> RUN on a multiply-class op (MULT, MULTU, MADD, MADDU, MSUB, MSUBU, MUL) while IDLE.
  - RUN -> FIN after 32 iterations.
  - FIN -> IDLE unconditionally.
- Start latch: captures |A|, |B| and a result-negate flag.
  - Signed ops (MULT, MADD, MSUB, MUL): negate flag = A[31]^B[31].
  - Unsigned ops: operands taken as-is, negate flag = 0.
  - Also latches op kind.
- RUN: shift-add, one multiplier bit per cycle, 64-bit product register; 5-bit counter runs 0..31.
- FIN: conditional two's-complement negate of the 64-bit product, then:
  - MULT/MULTU: {HI,LO} = P.
  - MADD/MADDU: {HI,LO} = {HI,LO} + P (mod 2^64).
  - MSUB/MSUBU: {HI,LO} = {HI,LO} - P (mod 2^64).
  - MUL: `MulOut` = P[31:0]; HI/LO unchanged.
  - In all cases `Done`=1 for this cycle.
- MTHI/MTLO: write A to HI or LO on the next edge when IDLE. Single cycle, no `Done`.
- MFHI/MFLO: `HiLoOut` = HI or LO combinationally when IDLE; otherwise 0.
- `Stall`:
  - Asserted for any valid op (MF*, MT*, or multiply-class) presented while state is RUN or FIN.
  - Asserted for MUL from issue until its FIN cycle inclusive, so the consumer holds until `MulOut` is valid.
  - Deasserted otherwise.
- A request arriving while not IDLE is never accepted. Upstream holds it under `Stall` and it is accepted in the first IDLE cycle.

## Timing
- Reset (async): state=IDLE, counter=0, HI=LO=0, `MulOut`=0, product=0, `Busy`=`Done`=`Stall`=0, `HiLoOut`=0.
- Issue at edge 0 (IDLE, op presented).
  - `Busy`=1 from cycle 1 through cycle 33.
  - `Done`=1 in cycle 33 only.
  - Results visible from cycle 34.
  - Total latency is 34 edges to architectural visibility.
- Back-to-back multiply: the second request is stalled through cycle 33 and accepted at the edge ending cycle 34. No gap beyond this.
- MT* in IDLE: new HI/LO visible on the next cycle. An MF* in the next cycle reads the new value.
- Reset asserted mid-RUN: the operation is abandoned, HI/LO are cleared, and no `Done` is produced.
- Overflow is never flagged; all accumulation wraps modulo 2^64.
- Operand 0x80000000 signed: |A| = 0x80000000 as unsigned, which is correct.

## Test plan
- MULT A=0xFFFFFFFD (-3), B=7 -> after `Done`, HI=0xFFFFFFFF, LO=0xFFFFFFEB; `Busy` high exactly 33 cycles.
- MULTU A=B=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001; then MULT on the same operands -> HI=0, LO=1.
- MTHI 0, MTLO 5, MADD A=2, B=3 -> HI=0, LO=0x0000000B. Then MSUBU A=1, B=0x0000000C -> HI=LO=0xFFFFFFFF (wrap).
- MUL A=0x00010000, B=0x00010000 with HI=LO=0x12345678 beforehand -> `MulOut`=0, HI/LO unchanged, `Stall` high until the `Done` cycle.
- Issue MULT, then MFLO on the next cycle -> `Stall`=1 through cycle 33; `HiLoOut` = new LO in cycle 34 with `Stall`=0.
- Reset asserted at iteration 10 of a MADD -> all outputs 0 immediately, no `Done`. The next MULT 4x5 gives LO=20, HI=0.

Source files
------------

// File: rtl/hilo_mul_unit.sv
`default_nettype none
// ============================================================================
// Module      : hilo_mul_unit
// Description : Iterative WIDTHxWIDTH multiply / multiply-accumulate unit with
//               architectural HI/LO registers. One multiplier bit is retired
//               per cycle on magnitudes. The sign is fixed up in the final
//               cycle, where the result is also committed. Stall interlocks
//               the execute stage against HI/LO and MulOut hazards.
// Revision    : 1.0 - initial release
// ============================================================================
module hilo_mul_unit #(
    parameter int WIDTH = 32
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             ALUOp,
    input  logic             MULOp,
    input  logic [5:0]       Func,
    input  logic             Valid,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             Busy,
    output logic             Done,
    output logic             Stall,
    output logic [WIDTH-1:0] HiLoOut,
    output logic [WIDTH-1:0] MulOut,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    localparam int c_CNT_W = $clog2(WIDTH);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(WIDTH - 1);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_RUN  = 2'd1;
    localparam logic [1:0] c_ST_FIN  = 2'd2;

    // Latched operation kind, selects how the final product is committed
    localparam logic [1:0] c_K_MULT = 2'd0;
    localparam logic [1:0] c_K_MADD = 2'd1;
    localparam logic [1:0] c_K_MSUB = 2'd2;
    localparam logic [1:0] c_K_MUL  = 2'd3;

    logic [1:0]         r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic [2*WIDTH-1:0] r_prod;
    logic [WIDTH-1:0]   r_mcand;
    logic               r_neg;
    logic [1:0]         r_kind;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic [WIDTH-1:0]   r_mul_out;

    logic w_mfhi, w_mflo, w_mthi, w_mtlo, w_mul_req, w_signed;
    logic [1:0] w_kind;

    // Decode the function code of a live request into one-hot op flags
    always_comb begin
        w_mfhi    = 1'b0;
        w_mflo    = 1'b0;
        w_mthi    = 1'b0;
        w_mtlo    = 1'b0;
        w_mul_req = 1'b0;
        w_signed  = 1'b0;
        w_kind    = c_K_MULT;
        if (Valid && ALUOp && !MULOp) begin
            case (Func)
                6'h10: w_mfhi = 1'b1;
                6'h11: w_mthi = 1'b1;
                6'h12: w_mflo = 1'b1;
                6'h13: w_mtlo = 1'b1;
                6'h18: begin w_mul_req = 1'b1; w_signed = 1'b1; w_kind = c_K_MULT; end
                6'h19: begin w_mul_req = 1'b1; w_kind = c_K_MULT; end
                default: ;
            endcase
        end else if (Valid && MULOp && !ALUOp) begin
            case (Func)
                6'h00: begin w_mul_req = 1'b1; w_signed = 1'b1; w_kind = c_K_MADD; end
                6'h01: begin w_mul_req = 1'b1; w_kind = c_K_MADD; end
                6'h02: begin w_mul_req = 1'b1; w_signed = 1'b1; w_kind = c_K_MUL; end
                6'h04: begin w_mul_req = 1'b1; w_signed = 1'b1; w_kind = c_K_MSUB; end
                6'h05: begin w_mul_req = 1'b1; w_kind = c_K_MSUB; end
                default: ;
            endcase
        end
    end

    logic                 w_idle;
    logic                 w_any_op;
    logic [WIDTH-1:0]     w_abs_a;
    logic [WIDTH-1:0]     w_abs_b;
    logic                 w_neg_start;
    logic [WIDTH-1:0]     w_addend;
    logic [WIDTH:0]       w_sum;
    logic [2*WIDTH-1:0]   w_prod_step;
    logic [2*WIDTH-1:0]   w_prod_fin;
    logic [2*WIDTH-1:0]   w_hilo;

    assign w_idle   = (r_state == c_ST_IDLE);
    assign w_any_op = w_mfhi | w_mflo | w_mthi | w_mtlo | w_mul_req;

    // The most negative operand negates to itself, which is its correct
    // magnitude when read as unsigned.
    assign w_abs_a     = (w_signed && A[WIDTH-1]) ? -A : A;
    assign w_abs_b     = (w_signed && B[WIDTH-1]) ? -B : B;
    assign w_neg_start = w_signed & (A[WIDTH-1] ^ B[WIDTH-1]);

    // Multiplier sits in the low half of the product register and is shifted
    // out as the partial sum is shifted in from the top.
    assign w_addend    = r_prod[0] ? r_mcand : '0;
    assign w_sum       = {1'b0, r_prod[2*WIDTH-1:WIDTH]} + {1'b0, w_addend};
    assign w_prod_step = {w_sum, r_prod[WIDTH-1:1]};
    assign w_prod_fin  = r_neg ? -r_prod : r_prod;
    assign w_hilo      = {r_hi, r_lo};

    // Sequencer and shift-add datapath
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_state <= c_ST_IDLE;
            r_cnt   <= '0;
            r_prod  <= '0;
            r_mcand <= '0;
            r_neg   <= 1'b0;
            r_kind  <= c_K_MULT;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_mul_req) begin
                        r_state <= c_ST_RUN;
                        r_cnt   <= '0;
                        r_prod  <= {{WIDTH{1'b0}}, w_abs_b};
                        r_mcand <= w_abs_a;
                        r_neg   <= w_neg_start;
                        r_kind  <= w_kind;
                    end
                end
                c_ST_RUN: begin
                    r_prod <= w_prod_step;
                    r_cnt  <= r_cnt + 1'b1;
                    if (r_cnt == c_CNT_LAST) begin
                        r_state <= c_ST_FIN;
                    end
                end
                c_ST_FIN: r_state <= c_ST_IDLE;
                default:  r_state <= c_ST_IDLE;
            endcase
        end
    end

    // Architectural HI/LO and MulOut: committed in FIN, or written by MT* when idle
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_hi      <= '0;
            r_lo      <= '0;
            r_mul_out <= '0;
        end else if (r_state == c_ST_FIN) begin
            case (r_kind)
                c_K_MULT: {r_hi, r_lo} <= w_prod_fin;
                c_K_MADD: {r_hi, r_lo} <= w_hilo + w_prod_fin;
                c_K_MSUB: {r_hi, r_lo} <= w_hilo - w_prod_fin;
                c_K_MUL:  r_mul_out    <= w_prod_fin[WIDTH-1:0];
                default:  ;
            endcase
        end else if (w_idle) begin
            if (w_mthi) r_hi <= A;
            if (w_mtlo) r_lo <= A;
        end
    end

    assign Busy    = !w_idle;
    assign Done    = (r_state == c_ST_FIN);
    // A MUL holds its consumer from issue until the FIN cycle, even once Valid drops
    assign Stall   = (!w_idle && (w_any_op || (r_kind == c_K_MUL))) ||
                     (w_idle && w_mul_req && (w_kind == c_K_MUL));
    assign HiLoOut = (w_idle && w_mfhi) ? r_hi :
                     (w_idle && w_mflo) ? r_lo : '0;
    assign MulOut  = r_mul_out;
    assign HI      = r_hi;
    assign LO      = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_hilo_mul_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_hilo_mul_unit
// Description : Self-checking bench for hilo_mul_unit. Expected HI/LO/MulOut
//               are computed from a 64-bit arithmetic model at issue time,
//               queued, and compared once Done has been observed.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hilo_mul_unit;

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic        ALUOp = 1'b0;
    logic        MULOp = 1'b0;
    logic [5:0]  Func  = 6'h00;
    logic        Valid = 1'b0;
    logic [31:0] A     = '0;
    logic [31:0] B     = '0;
    logic        Busy, Done, Stall;
    logic [31:0] HiLoOut, MulOut, HI, LO;

    int n_checks = 0;
    int n_fail   = 0;

    // Scoreboard entry: {HI, LO, MulOut} expected after the op commits
    logic [95:0] sb[$];
    logic [31:0] m_hi  = '0;
    logic [31:0] m_lo  = '0;
    logic [31:0] m_mul = '0;

    hilo_mul_unit #(.WIDTH(32)) dut (
        .Clock   (Clock),
        .Reset   (Reset),
        .ALUOp   (ALUOp),
        .MULOp   (MULOp),
        .Func    (Func),
        .Valid   (Valid),
        .A       (A),
        .B       (B),
        .Busy    (Busy),
        .Done    (Done),
        .Stall   (Stall),
        .HiLoOut (HiLoOut),
        .MulOut  (MulOut),
        .HI      (HI),
        .LO      (LO)
    );

    always #5 Clock = ~Clock;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic drive(input logic alu, input logic mul, input logic [5:0] f,
                         input logic [31:0] a, input logic [31:0] b);
        ALUOp = alu;
        MULOp = mul;
        Func  = f;
        A     = a;
        B     = b;
        Valid = 1'b1;
    endtask

    task automatic idle_in();
        Valid = 1'b0;
        ALUOp = 1'b0;
        MULOp = 1'b0;
    endtask

    // kind: 0 MULT/MULTU, 1 MADD/MADDU, 2 MSUB/MSUBU, 3 MUL
    task automatic model_push(input int kind, input bit sgn, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] ea, eb, p, hl;
        ea = sgn ? {{32{a[31]}}, a} : {32'h0, a};
        eb = sgn ? {{32{b[31]}}, b} : {32'h0, b};
        p  = ea * eb;
        hl = {m_hi, m_lo};
        case (kind)
            0: hl = p;
            1: hl = hl + p;
            2: hl = hl - p;
            default: m_mul = p[31:0];
        endcase
        m_hi = hl[63:32];
        m_lo = hl[31:0];
        sb.push_back({m_hi, m_lo, m_mul});
    endtask

    // Hold the driven request until the unit is idle, then let one edge take it
    task automatic accept(input int kind);
        int waited = 0;
        #1;
        while (Busy && waited < 100) begin
            @(negedge Clock);
            waited++;
        end
        if (Busy) check("accept_timeout", 1, 0);
        if (kind == 3) check("mul_issue_stall", Stall, 1);
        @(posedge Clock);
        #1;
    endtask

    task automatic issue_mul(input logic alu, input logic mul, input logic [5:0] f,
                             input logic [31:0] a, input logic [31:0] b,
                             input bit sgn, input int kind);
        model_push(kind, sgn, a, b);
        drive(alu, mul, f, a, b);
        accept(kind);
    endtask

    task automatic mt_op(input logic [5:0] f, input logic [31:0] a);
        drive(1'b1, 1'b0, f, a, 32'h0);
        accept(-1);
        idle_in();
        if (f == 6'h11) m_hi = a;
        else            m_lo = a;
    endtask

    task automatic mf_check(input string tag, input logic [5:0] f, input logic [31:0] exp);
        drive(1'b1, 1'b0, f, 32'h0, 32'h0);
        #1;
        check(tag, HiLoOut, exp);
        idle_in();
    endtask

    // Observe cycles 1..34 after the issue edge; commit results checked in cycle 34
    task automatic monitor(input int kind, input bit follow, input bit mflo);
        int busy_cnt = 0, done_cnt = 0, done_at = -1, stall_cnt = 0;
        logic [95:0] e = '0;
        for (int cyc = 1; cyc <= 34; cyc++) begin
            @(negedge Clock);
            if (cyc <= 33) begin
                if (Busy)  busy_cnt++;
                if (Stall) stall_cnt++;
            end
            if (Done) begin
                done_cnt++;
                done_at = cyc;
                if (sb.size() > 0) e = sb.pop_front();
            end
        end
        check("busy_cycles", busy_cnt, 33);
        check("done_at", done_at, 33);
        check("done_count", done_cnt, 1);
        check("hi", HI, e[95:64]);
        check("lo", LO, e[63:32]);
        check("mulout", MulOut, e[31:0]);
        check("busy_end", Busy, 0);
        check("stall_end", Stall, 0);
        if (kind == 3 || follow) check("stall_cycles", stall_cnt, 33);
        else                     check("stall_cycles_none", stall_cnt, 0);
        if (mflo) check("mflo_after_mult", HiLoOut, m_lo);
    endtask

    initial begin
        int dcnt;

        // Reset state
        repeat (2) @(posedge Clock);
        @(negedge Clock);
        check("rst_hi", HI, 0);
        check("rst_lo", LO, 0);
        check("rst_mulout", MulOut, 0);
        check("rst_busy", Busy, 0);
        check("rst_done", Done, 0);
        check("rst_stall", Stall, 0);
        check("rst_hilo_out", HiLoOut, 0);
        @(posedge Clock);
        #1;
        Reset = 1'b0;

        // MULT -3 * 7
        issue_mul(1'b1, 1'b0, 6'h18, 32'hFFFF_FFFD, 32'd7, 1'b1, 0);
        idle_in();
        monitor(0, 1'b0, 1'b0);

        // MULTU and MULT on all-ones
        issue_mul(1'b1, 1'b0, 6'h19, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0);
        idle_in();
        monitor(0, 1'b0, 1'b0);
        issue_mul(1'b1, 1'b0, 6'h18, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 0);
        idle_in();
        monitor(0, 1'b0, 1'b0);

        // MTHI/MTLO then MADD, then MSUBU wrapping below zero
        mt_op(6'h11, 32'h0);
        mt_op(6'h13, 32'd5);
        mf_check("mflo_after_mtlo", 6'h12, 32'd5);
        issue_mul(1'b0, 1'b1, 6'h00, 32'd2, 32'd3, 1'b1, 1);
        idle_in();
        monitor(1, 1'b0, 1'b0);
        issue_mul(1'b0, 1'b1, 6'h05, 32'd1, 32'h0000_000C, 1'b0, 2);
        idle_in();
        monitor(2, 1'b0, 1'b0);

        // MUL leaves HI/LO untouched and stalls until its Done cycle
        mt_op(6'h11, 32'h1234_5678);
        mt_op(6'h13, 32'h1234_5678);
        mf_check("mfhi_after_mthi", 6'h10, 32'h1234_5678);
        issue_mul(1'b0, 1'b1, 6'h02, 32'h0001_0000, 32'h0001_0000, 1'b1, 3);
        idle_in();
        monitor(3, 1'b0, 1'b0);
        issue_mul(1'b0, 1'b1, 6'h02, 32'hFFFF_FFFA, 32'd7, 1'b1, 3);
        idle_in();
        monitor(3, 1'b0, 1'b0);

        // MFLO held behind a MULT
        issue_mul(1'b1, 1'b0, 6'h18, 32'd6, 32'd7, 1'b1, 0);
        drive(1'b1, 1'b0, 6'h12, 32'h0, 32'h0);
        monitor(0, 1'b1, 1'b1);
        idle_in();

        // Back-to-back: second request held under Stall, taken at the edge ending cycle 34
        issue_mul(1'b1, 1'b0, 6'h18, 32'd3, 32'd5, 1'b1, 0);
        drive(1'b1, 1'b0, 6'h19, 32'd2, 32'd9);
        monitor(0, 1'b1, 1'b0);
        model_push(0, 1'b0, 32'd2, 32'd9);
        @(posedge Clock);
        #1;
        idle_in();
        monitor(0, 1'b0, 1'b0);

        // Reset at iteration 10 of a MADD
        issue_mul(1'b0, 1'b1, 6'h00, 32'd9, 32'd9, 1'b1, 1);
        idle_in();
        repeat (10) @(posedge Clock);
        #2;
        Reset = 1'b1;
        #1;
        check("midrst_hi", HI, 0);
        check("midrst_lo", LO, 0);
        check("midrst_mulout", MulOut, 0);
        check("midrst_busy", Busy, 0);
        check("midrst_done", Done, 0);
        check("midrst_stall", Stall, 0);
        check("midrst_hilo_out", HiLoOut, 0);
        sb.delete();
        m_hi  = '0;
        m_lo  = '0;
        m_mul = '0;
        @(posedge Clock);
        #1;
        Reset = 1'b0;
        dcnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge Clock);
            if (Done) dcnt++;
        end
        check("no_done_after_reset", dcnt, 0);
        check("idle_after_reset", Busy, 0);

        issue_mul(1'b1, 1'b0, 6'h18, 32'd4, 32'd5, 1'b1, 0);
        idle_in();
        monitor(0, 1'b0, 1'b0);

        check("scoreboard_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
